// File: rtl/branch_predict_unit.sv
// branch_predict_unit: execute-stage branch resolution with a 2-bit BHT.
// Optional stats counters behind BRANCH_STATS_EN.
//
// Ports:
//   clk, rst           clock, async active-high reset
//   pred_req/pred_pc   fetch lookup -> pred_valid/pred_taken (1 cycle)
//   Branch_Flag, ALUOp, Data1, Data2, Target, next_pc, res_pred_taken
//                      resolve request -> res_valid, zero, Branch_address,
//                      mispredict, redirect_pc (1 cycle)
//   branch_count, mispredict_count  (BRANCH_STATS_EN only)
module branch_predict_unit #(
  parameter int DATA_W    = 32,
  parameter int OFF_W     = 16,
  parameter int BHT_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pred_req,
  input  logic [DATA_W-1:0] pred_pc,
  output logic              pred_valid,
  output logic              pred_taken,
  input  logic              Branch_Flag,
  input  logic [3:0]        ALUOp,
  input  logic [DATA_W-1:0] Data1,
  input  logic [DATA_W-1:0] Data2,
  input  logic [OFF_W-1:0]  Target,
  input  logic [DATA_W-1:0] next_pc,
  input  logic              res_pred_taken,
  output logic              res_valid,
  output logic              zero,
  output logic [DATA_W-1:0] Branch_address,
  output logic              mispredict,
  output logic [DATA_W-1:0] redirect_pc
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]       branch_count,
  output logic [31:0]       mispredict_count
`endif
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [1:0]        bht_q [BHT_DEPTH];
  logic              pred_valid_q;
  logic              pred_taken_q;
  logic              res_valid_q;
  logic              zero_q;
  logic              mispredict_q;
  logic [DATA_W-1:0] br_addr_q;
  logic [DATA_W-1:0] redir_q;

  logic [DATA_W-1:0] off_ext;
  logic [DATA_W-1:0] tgt;
  logic [DATA_W-1:0] br_pc;
  logic [IDX_W-1:0]  pidx;
  logic [IDX_W-1:0]  ridx;
  logic              cond;
  logic              op_ok;
  logic              upd;
  logic              mp;
  logic [1:0]        ctr;
  logic [1:0]        ctr_d;
  logic              d1_neg;
  logic              d1_zero;

  assign off_ext = {{(DATA_W-OFF_W){Target[OFF_W-1]}}, Target};
  assign tgt     = next_pc + (off_ext << 2);
  // The branch's own PC selects the entry it trains.
  assign br_pc   = next_pc - DATA_W'(4);
  assign pidx    = pred_pc[IDX_W+1:2];
  assign ridx    = br_pc[IDX_W+1:2];
  assign d1_neg  = Data1[DATA_W-1];
  assign d1_zero = (Data1 == '0);

  always_comb begin
    cond  = 1'b0;
    op_ok = 1'b1;
    case (ALUOp)
      4'b0100: cond = (Data1 == Data2);
      4'b0101: cond = (Data1 != Data2);
      4'b0110: cond = d1_neg | d1_zero;
      4'b0111: cond = ~d1_neg & ~d1_zero;
      4'b1000: cond = d1_neg;
      4'b1001: cond = ~d1_neg;
      default: op_ok = 1'b0;
    endcase
  end

  assign upd = Branch_Flag & op_ok;
  assign mp  = Branch_Flag & (cond != res_pred_taken);
  assign ctr = bht_q[ridx];

  always_comb begin
    ctr_d = ctr;
    if (cond) begin
      if (ctr != 2'b11) ctr_d = ctr + 2'd1;
    end else begin
      if (ctr != 2'b00) ctr_d = ctr - 2'd1;
    end
  end

  // Lookup reads bht_q before this edge's update lands (no bypass).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
    end else if (upd) begin
      bht_q[ridx] <= ctr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
    end else begin
      pred_valid_q <= pred_req;
      if (pred_req) pred_taken_q <= bht_q[pidx][1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q  <= 1'b0;
      zero_q       <= 1'b0;
      mispredict_q <= 1'b0;
      br_addr_q    <= '0;
      redir_q      <= '0;
    end else begin
      res_valid_q  <= Branch_Flag;
      zero_q       <= Branch_Flag & cond;
      mispredict_q <= mp;
      if (Branch_Flag) begin
        br_addr_q <= tgt;
        redir_q   <= cond ? tgt : next_pc;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] br_cnt_q;
  logic [31:0] mp_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      if (upd) br_cnt_q <= br_cnt_q + 32'd1;
      if (mp)  mp_cnt_q <= mp_cnt_q + 32'd1;
    end
  end

  assign branch_count     = br_cnt_q;
  assign mispredict_count = mp_cnt_q;
`endif

  assign pred_valid     = pred_valid_q;
  assign pred_taken     = pred_taken_q;
  assign res_valid      = res_valid_q;
  assign zero           = zero_q;
  assign mispredict     = mispredict_q;
  assign Branch_address = br_addr_q;
  assign redirect_pc    = redir_q;

  logic unused_bits;
  assign unused_bits = ^{pred_pc[DATA_W-1:IDX_W+2], pred_pc[1:0],
                         br_pc[DATA_W-1:IDX_W+2], br_pc[1:0]};

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed vectors, per-cycle model compare
// plus literal expectations for branch_predict_unit.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pred_req = 1'b0;
  logic [31:0] pred_pc = '0;
  logic        pred_valid;
  logic        pred_taken;
  logic        Branch_Flag = 1'b0;
  logic [3:0]  ALUOp = '0;
  logic [31:0] Data1 = '0;
  logic [31:0] Data2 = '0;
  logic [15:0] Target = '0;
  logic [31:0] next_pc = '0;
  logic        res_pred_taken = 1'b0;
  logic        res_valid;
  logic        zero;
  logic [31:0] Branch_address;
  logic        mispredict;
  logic [31:0] redirect_pc;
`ifdef BRANCH_STATS_EN
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predict_unit dut (
    .clk(clk), .rst(rst),
    .pred_req(pred_req), .pred_pc(pred_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .Branch_Flag(Branch_Flag), .ALUOp(ALUOp),
    .Data1(Data1), .Data2(Data2), .Target(Target),
    .next_pc(next_pc), .res_pred_taken(res_pred_taken),
    .res_valid(res_valid), .zero(zero),
    .Branch_address(Branch_address), .mispredict(mispredict),
    .redirect_pc(redirect_pc)
`ifdef BRANCH_STATS_EN
    , .branch_count(branch_count),
    .mispredict_count(mispredict_count)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, a, e);
    end
  endtask

  // Model: counters as plain ints in 0..3, conditions as signed math.
  int          m_ctr [16];
  logic        e_pv, e_pt, e_rv, e_zero, e_mp;
  logic [31:0] e_ba, e_rp, e_bc, e_mc;

  function automatic bit m_taken(input logic [3:0] op,
                                 input logic [31:0] a, b);
    int sa;
    sa = int'($signed(a));
    case (op)
      4'd4: return a == b;
      4'd5: return a != b;
      4'd6: return sa <= 0;
      4'd7: return sa > 0;
      4'd8: return sa < 0;
      4'd9: return sa >= 0;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    bit tk;
    bit known;
    int ix;
    if (rst) begin
      for (int i = 0; i < 16; i++) m_ctr[i] = 1;
      e_pv = 0; e_pt = 0; e_rv = 0; e_zero = 0; e_mp = 0;
      e_ba = 0; e_rp = 0; e_bc = 0; e_mc = 0;
    end else begin
      e_pv = pred_req;
      if (pred_req) e_pt = (m_ctr[(pred_pc >> 2) % 16] >= 2);
      tk    = m_taken(ALUOp, Data1, Data2);
      known = (ALUOp >= 4) && (ALUOp <= 9);
      e_rv  = Branch_Flag;
      e_zero = Branch_Flag && tk;
      e_mp  = Branch_Flag && (tk != res_pred_taken);
      if (Branch_Flag) begin
        e_ba = next_pc + 32'(int'($signed(Target)) * 4);
        e_rp = tk ? e_ba : next_pc;
      end
      if (Branch_Flag && known) begin
        ix = int'(((next_pc - 32'd4) >> 2) % 16);
        if (tk) m_ctr[ix] = (m_ctr[ix] + 1 > 3) ? 3 : m_ctr[ix] + 1;
        else    m_ctr[ix] = (m_ctr[ix] - 1 < 0) ? 0 : m_ctr[ix] - 1;
        e_bc = e_bc + 1;
      end
      if (e_mp) e_mc = e_mc + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_pred_valid", 32'(pred_valid), 32'(e_pv));
      chk("m_pred_taken", 32'(pred_taken), 32'(e_pt));
      chk("m_res_valid", 32'(res_valid), 32'(e_rv));
      chk("m_mispredict", 32'(mispredict), 32'(e_mp));
      if (e_rv) begin
        chk("m_zero", 32'(zero), 32'(e_zero));
        chk("m_branch_address", Branch_address, e_ba);
        chk("m_redirect_pc", redirect_pc, e_rp);
      end
`ifdef BRANCH_STATS_EN
      chk("m_branch_count", branch_count, e_bc);
      chk("m_mispredict_count", mispredict_count, e_mc);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    pred_req    = 1'b0;
    Branch_Flag = 1'b0;
  endtask

  task automatic set_res(input logic [3:0] op, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [15:0] tg,
                         input logic [31:0] np, input logic pt);
    Branch_Flag    = 1'b1;
    ALUOp          = op;
    Data1          = d1;
    Data2          = d2;
    Target         = tg;
    next_pc        = np;
    res_pred_taken = pt;
  endtask

  task automatic do_res(input logic [3:0] op, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [15:0] tg,
                        input logic [31:0] np, input logic pt);
    set_res(op, d1, d2, tg, np, pt);
    tick();
  endtask

  task automatic lookup(input logic [31:0] pc);
    pred_req = 1'b1;
    pred_pc  = pc;
    tick();
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({nm, "_zero"}, 32'(zero), 32'd0);
    chk({nm, "_mispredict"}, 32'(mispredict), 32'd0);
    chk({nm, "_branch_address"}, Branch_address, 32'd0);
    chk({nm, "_redirect_pc"}, redirect_pc, 32'd0);
    chk({nm, "_pred_valid"}, 32'(pred_valid), 32'd0);
    chk({nm, "_pred_taken"}, 32'(pred_taken), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // BEQ taken, forward offset
    do_res(4'b0100, 32'd1, 32'd1, 16'h0001, 32'd4, 1'b0);
    chk("beq_zero", 32'(zero), 32'd1);
    chk("beq_addr", Branch_address, 32'd8);
    chk("beq_redirect", redirect_pc, 32'd8);
    chk("beq_mispredict", 32'(mispredict), 32'd1);

    // BNE equal then unequal
    do_res(4'b0101, 32'd1, 32'd1, 16'h0001, 32'd8, 1'b0);
    chk("bne_eq_zero", 32'(zero), 32'd0);
    chk("bne_eq_redirect", redirect_pc, 32'd8);
    do_res(4'b0101, 32'd1, 32'h10, 16'h0001, 32'd8, 1'b0);
    chk("bne_ne_zero", 32'(zero), 32'd1);
    chk("bne_ne_redirect", redirect_pc, 32'd12);

    // BLTZ signed with negative offset
    do_res(4'b1000, 32'hFFFF_FFFF, 32'd0, 16'hFFFF, 32'h100, 1'b1);
    chk("bltz_zero", 32'(zero), 32'd1);
    chk("bltz_addr", Branch_address, 32'hFC);
    chk("bltz_mispredict", 32'(mispredict), 32'd0);

    // Unknown op: not taken, mispredict against a taken guess
    do_res(4'b0000, 32'd3, 32'd3, 16'h0004, 32'h20, 1'b1);
    chk("bad_op_zero", 32'(zero), 32'd0);
    chk("bad_op_redirect", redirect_pc, 32'h20);
    chk("bad_op_mispredict", 32'(mispredict), 32'd1);

    // Address wrap at 2^32
    do_res(4'b0100, 32'd0, 32'd0, 16'h0002, 32'hFFFF_FFFC, 1'b1);
    chk("wrap_addr", Branch_address, 32'h4);
    tick();
    chk("idle_res_valid", 32'(res_valid), 32'd0);

    // Saturation on index 0
    pulse_rst();
    repeat (3) do_res(4'b0100, 32'd5, 32'd5, 16'h0, 32'd4, 1'b0);
    lookup(32'd0);
    chk("sat_3t_taken", 32'(pred_taken), 32'd1);
    do_res(4'b0100, 32'd5, 32'd5, 16'h0, 32'd4, 1'b1);
    do_res(4'b0101, 32'd5, 32'd5, 16'h0, 32'd4, 1'b1);
    lookup(32'd0);
    chk("sat_4t1n_taken", 32'(pred_taken), 32'd1);

    // Reset mid-stream with a resolve and lookup in flight
    pred_req = 1'b1;
    pred_pc  = 32'd0;
    set_res(4'b0100, 32'd7, 32'd7, 16'h0010, 32'd4, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    set_res(4'b0100, 32'd7, 32'd7, 16'h0010, 32'd4, 1'b0);
    tick();
    rst = 1'b0;
    lookup(32'd0);
    chk("rst_ctr_lookup", 32'(pred_taken), 32'd0);
    do_res(4'b0100, 32'd1, 32'd1, 16'h0, 32'd4, 1'b0);
    lookup(32'd0);
    chk("rst_ctr_is_01", 32'(pred_taken), 32'd1);
    do_res(4'b0101, 32'd1, 32'd1, 16'h0, 32'd4, 1'b0);
    do_res(4'b0101, 32'd1, 32'd1, 16'h0, 32'd4, 1'b0);
    lookup(32'd0);
    chk("sat_low_taken", 32'(pred_taken), 32'd0);

    // Same-index lookup and update on one edge
    pulse_rst();
    pred_req = 1'b1;
    pred_pc  = 32'd0;
    set_res(4'b0100, 32'd2, 32'd2, 16'h0, 32'd4, 1'b0);
    tick();
    chk("coll_pred_valid", 32'(pred_valid), 32'd1);
    chk("coll_pred_taken", 32'(pred_taken), 32'd0);
    lookup(32'd0);
    chk("coll_next_taken", 32'(pred_taken), 32'd1);

    // Five branches, two mispredicts
    pulse_rst();
    do_res(4'b0100, 32'd9, 32'd9, 16'h1, 32'h40, 1'b1);
    do_res(4'b0101, 32'd9, 32'd8, 16'h1, 32'h44, 1'b0);
    do_res(4'b0110, 32'd0, 32'd0, 16'h1, 32'h48, 1'b1);
    do_res(4'b0111, 32'd0, 32'd0, 16'h1, 32'h4C, 1'b1);
    do_res(4'b1001, 32'd5, 32'd0, 16'h1, 32'h50, 1'b1);
`ifdef BRANCH_STATS_EN
    chk("stats_branches", branch_count, 32'd5);
    chk("stats_mispredicts", mispredict_count, 32'd2);
    pulse_rst();
    chk("stats_rst_branches", branch_count, 32'd0);
    chk("stats_rst_mispredicts", mispredict_count, 32'd0);
`endif
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised branch resolution unit with a dynamic direction predictor. It evaluates conditional branches at execute from two register operands and a 4-bit ALUOp, computes the PC-relative target, and flags mispredictions against the prediction carried down the pipeline. It also keeps a table of 2-bit saturating counters that the fetch stage queries one cycle ahead. It sits between the register-read/execute stage and the PC-select logic.

## Interface
- DATA_W, 32, operand/PC width
- OFF_W, 16, branch offset (Target) width; sign-extended to DATA_W
- BHT_DEPTH, 16, predictor entries; power of two, >= 2 (IDX_W = log2(BHT_DEPTH))

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- pred_req  in  1  fetch lookup request
- pred_pc  in  DATA_W  fetch PC; index = pred_pc[IDX_W+1:2]
- pred_valid  out  1  lookup result valid (pred_req delayed 1 cycle)
- pred_taken  out  1  MSB of indexed counter
- Branch_Flag  in  1  resolve request (instruction is a branch)
- ALUOp  in  4  branch condition select
- Data1, Data2  in  DATA_W  operands (rs, rt)
- Target  in  OFF_W  word offset
- next_pc  in  DATA_W  PC+4 of the branch; index = (next_pc-4)[IDX_W+1:2]
- res_pred_taken  in  1  prediction made at fetch for this branch
- res_valid  out  1  resolve outputs valid
- zero  out  1  condition true (branch taken)
- Branch_address  out  DATA_W  next_pc + (sext(Target) << 2)
- mispredict  out  1  zero != res_pred_taken, qualified by res_valid
- redirect_pc  out  DATA_W  Branch_address if taken, else next_pc
- branch_count, mispredict_count  out  32  present only with BRANCH_STATS_EN

## Operation
- Conditions (signed compare for relational ops): 4'b0100 BEQ Data1==Data2; 4'b0101 BNE Data1!=Data2; 4'b0110 BLEZ Data1<=0; 4'b0111 BGTZ Data1>0; 4'b1000 BLTZ Data1<0; 4'b1001 BGEZ Data1>=0. Any other ALUOp: not taken, and the BHT is not updated. mispredict is still evaluated as res_pred_taken != 0.
- Address arithmetic is modulo 2^DATA_W and wraps silently. Branch_address is computed regardless of the condition.
- BHT entry: 2-bit saturating counter, 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Taken increments and saturates at 11. Not-taken decrements and saturates at 00.
- Update is committed on the clock edge that registers the resolve, for valid-ALUOp branches only.
- Reset: all counters 01; pred_valid, pred_taken, res_valid, zero, mispredict 0; Branch_address, redirect_pc 0; stats counters 0. Reset mid-operation discards in-flight results.

## Timing
- Lookup: pred_req/pred_pc sampled at edge N. pred_valid/pred_taken are registered and valid after edge N, held until edge N+1. Without pred_req, pred_valid=0 and pred_taken holds its last value.
- Resolve: Branch_Flag and operands sampled at edge N. All res_* outputs are registered and valid for one cycle after edge N. A new resolve is accepted every cycle with no stall.
- When a lookup and an update hit the same index on the same edge, the lookup returns the pre-update counter (read-before-write), with no bypass.
- A resolve with Branch_Flag=0 gives res_valid=0 and mispredict=0, and the BHT is unchanged.

## Configuration
- BRANCH_STATS_EN defined:
  - branch_count increments on every res_valid cycle with a valid ALUOp.
  - mispredict_count increments on every mispredict.
  - Both are 32-bit, wrap at 2^32, and are cleared by rst.
- BRANCH_STATS_EN undefined: both ports and counters are absent; behaviour is otherwise identical.

## Test plan
- BEQ taken: ALUOp=0100, Data1=Data2=1, Target=16'h0001, next_pc=4, res_pred_taken=0. Next cycle: zero=1, Branch_address=8, redirect_pc=8, mispredict=1.
- BNE equal: ALUOp=0101, Data1=Data2=1. Result: zero=0, redirect_pc=4. Data2=32'h10 gives zero=1.
- Signed compare and negative offset: BLTZ with Data1=32'hFFFFFFFF, Target=16'hFFFF, next_pc=32'h100. Result: zero=1, Branch_address=32'hFC.
- Counter saturation: after reset, three taken resolves at next_pc=4 (index 0). A lookup at pred_pc=0 returns pred_taken=1. Two not-taken resolves then return pred_taken=0. A fourth taken resolve leaves the counter at 11.
- Same-index collision: a lookup and a taken update on index 0 from state 01 on the same edge return pred_taken=0. The next lookup returns 1.
- Reset/stats: assert rst mid-stream, then check all outputs are 0 and counters are 01. With BRANCH_STATS_EN, 5 branches including 2 mispredicts give counts of 5 and 2.
